// File: rtl/updown_counter_n_pkg.sv
// Shared definitions for the updown_counter_n block.
//   DIR_UP / DIR_DN      : encodings of the 'up' direction input
//   MODE_WRAP / MODE_SAT : values of the SATURATE parameter
//   step_op_e            : operation selected by the next-value generator
package updown_counter_n_pkg;

  localparam logic        DIR_UP    = 1'b1;
  localparam logic        DIR_DN    = 1'b0;
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [1:0] {
    StepHold,
    StepLoad,
    StepInc,
    StepDec
  } step_op_e;

endpackage

// File: rtl/count_step.sv
// Combinational next-value and wrap-flag generator for updown_counter_n.
//   q         in   WIDTH  current count
//   up        in   1      direction (DIR_UP / DIR_DN)
//   adv       in   1      advance qualifier (en & cin)
//   load      in   1      parallel load request, overrides adv
//   d         in   WIDTH  load value, clamped to MODULUS-1
//   q_next    out  WIDTH  value to register on the next edge
//   wrap_next out  1      high when this step rolls over (wrap mode only)
module count_step
  import updown_counter_n_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);

  // One extra bit so the clamp compare and +1 never overflow, even when
  // MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0] MaxVal = (WIDTH + 1)'(MODULUS - 1);
  localparam bit             Holds  = (SATURATE == MODE_SAT);
  localparam bit             Wraps  = (SATURATE == MODE_WRAP);

  step_op_e       op;
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] nxt_ext;

  always_comb begin
    if (load) begin
      op = StepLoad;
    end else if (adv) begin
      op = (up == DIR_DN) ? StepDec : StepInc;
    end else begin
      op = StepHold;
    end
  end

  always_comb begin
    q_ext     = {1'b0, q};
    d_ext     = {1'b0, d};
    nxt_ext   = q_ext;
    wrap_next = 1'b0;
    unique case (op)
      StepLoad: begin
        nxt_ext = (d_ext > MaxVal) ? MaxVal : d_ext;
      end
      StepInc: begin
        if (q_ext == MaxVal) begin
          nxt_ext   = Holds ? q_ext : '0;
          wrap_next = Wraps;
        end else begin
          nxt_ext = q_ext + 1'b1;
        end
      end
      StepDec: begin
        if (q_ext == '0) begin
          nxt_ext   = Holds ? q_ext : MaxVal;
          wrap_next = Wraps;
        end else begin
          nxt_ext = q_ext - 1'b1;
        end
      end
      default: begin
        nxt_ext = q_ext;
      end
    endcase
    q_next = WIDTH'(nxt_ext);
  end

endmodule

// File: rtl/updown_counter_n.sv
// Cascadable synchronous up/down counter with modulus, load and wrap/saturate.
//   clk   in   1      clock, rising edge
//   clr   in   1      asynchronous active-high reset
//   en    in   1      count enable
//   cin   in   1      cascade carry in (tie 1 when unchained)
//   up    in   1      direction: 1 = up, 0 = down
//   load  in   1      synchronous parallel load (beats counting)
//   d     in   WIDTH  load value
//   q     out  WIDTH  current count
//   tc    out  1      terminal count for the current direction (combinational)
//   cout  out  1      tc & en & cin, feeds the next stage's cin
//   wrap  out  1      registered one-cycle pulse after a rollover edge
module updown_counter_n
  import updown_counter_n_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             adv;

  assign adv = en & cin;

  count_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_count_step (
    .q        (count_q),
    .up       (up),
    .adv      (adv),
    .load     (load),
    .d        (d),
    .q_next   (count_d),
    .wrap_next(wrap_d)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  // Terminal count follows 'up' immediately so a direction change is seen
  // by the cascade in the same cycle.
  assign tc   = (up == DIR_UP) ? (count_q == MaxQ) : (count_q == '0);
  assign cout = tc & en & cin;

endmodule

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;
  import updown_counter_n_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic         clk = 1'b0;
  logic         clr;
  logic         en, cin, up, load;
  logic [W-1:0] d;
  logic [W-1:0] q_a, q_s;
  logic         tc_a, cout_a, wrap_a, tc_s, cout_s, wrap_s;

  logic         c_clr, c_en;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tc, lo_cout, lo_wrap, hi_tc, hi_cout, hi_wrap;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(MODE_WRAP)) dut_a (
    .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .d(d),
    .q(q_a), .tc(tc_a), .cout(cout_a), .wrap(wrap_a)
  );

  updown_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(MODE_SAT)) dut_s (
    .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .d(d),
    .q(q_s), .tc(tc_s), .cout(cout_s), .wrap(wrap_s)
  );

  updown_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(MODE_WRAP)) dut_lo (
    .clk(clk), .clr(c_clr), .en(c_en), .cin(1'b1), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(lo_q), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap)
  );

  updown_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(MODE_WRAP)) dut_hi (
    .clk(clk), .clr(c_clr), .en(c_en), .cin(lo_cout), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(hi_q), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts modulo M, load clamps, saturation pins at the end.
  function automatic int model_q(input int cur, input bit sat, input bit ld, input int dv,
                                 input bit adv, input bit dir_up);
    if (ld) return (dv > int'(M) - 1) ? int'(M) - 1 : dv;
    if (!adv) return cur;
    if (dir_up) begin
      if (cur == int'(M) - 1) return sat ? cur : 0;
      return cur + 1;
    end
    if (cur == 0) return sat ? cur : int'(M) - 1;
    return cur - 1;
  endfunction

  function automatic bit model_w(input int cur, input bit sat, input bit ld,
                                 input bit adv, input bit dir_up);
    if (ld || !adv || sat) return 1'b0;
    return dir_up ? (cur == int'(M) - 1) : (cur == 0);
  endfunction

  int m_a = 0, m_s = 0;
  bit mw_a = 1'b0, mw_s = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_a  <= 0;
      m_s  <= 0;
      mw_a <= 1'b0;
      mw_s <= 1'b0;
    end else begin
      m_a  <= model_q(m_a, 1'b0, load, int'(d), en && cin, up);
      m_s  <= model_q(m_s, 1'b1, load, int'(d), en && cin, up);
      mw_a <= model_w(m_a, 1'b0, load, en && cin, up);
      mw_s <= model_w(m_s, 1'b1, load, en && cin, up);
    end
  end

  // Every-cycle comparison of both shared-input instances against the model.
  always @(posedge clk) begin
    #2;
    if (checking && !clr) begin
      chk("model_q_wrap", q_a, m_a);
      chk("model_wrap_wrap", wrap_a, mw_a);
      chk("model_tc_wrap", tc_a, up ? (m_a == int'(M) - 1) : (m_a == 0));
      chk("model_cout_wrap", cout_a, (up ? (m_a == int'(M) - 1) : (m_a == 0)) && en && cin);
      chk("model_q_sat", q_s, m_s);
      chk("model_wrap_sat", wrap_s, mw_s);
      chk("model_tc_sat", tc_s, up ? (m_s == int'(M) - 1) : (m_s == 0));
      chk("model_cout_sat", cout_s, (up ? (m_s == int'(M) - 1) : (m_s == 0)) && en && cin);
    end
  end

  initial begin
    clr = 1'b1; en = 1'b0; cin = 1'b1; up = 1'b1; load = 1'b0; d = '0;
    c_clr = 1'b1; c_en = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0; c_clr = 1'b0; checking = 1'b1;
    #1;
    chk("reset_q", q_a, 0);
    chk("reset_wrap", wrap_a, 0);
    chk("reset_tc_up", tc_a, 0);
    chk("reset_cout", cout_a, 0);

    // Asynchronous clear mid-count.
    @(negedge clk); load = 1'b1; d = 4'd7;
    @(negedge clk); load = 1'b0;
    #1 chk("preclr_q", q_a, 7);
    #2 clr = 1'b1;
    #1;
    chk("async_clr_q", q_a, 0);
    chk("async_clr_wrap", wrap_a, 0);
    chk("async_clr_q_sat", q_s, 0);
    @(negedge clk); clr = 1'b0;

    // Up count through wrap.
    en = 1'b1; cin = 1'b1; up = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      chk("up_q", q_a, i % 10);
      chk("up_tc", tc_a, (i == 9));
      chk("up_cout", cout_a, (i == 9));
      chk("up_wrap", wrap_a, (i == 10));
      @(negedge clk);
    end
    #1;
    chk("up_after_wrap_q", q_a, 1);
    chk("up_after_wrap_pulse", wrap_a, 0);

    // Saturating down count.
    @(negedge clk); load = 1'b1; d = 4'd2; up = 1'b0;
    @(negedge clk); load = 1'b0;
    #1 chk("sat_load_q", q_s, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("sat_dn_q", q_s, (k < 2) ? 1 - k : 0);
      chk("sat_dn_tc", tc_s, (k >= 1));
      chk("sat_dn_wrap", wrap_s, 0);
    end

    // Load priority and clamp.
    @(negedge clk); load = 1'b1; d = 4'd9; up = 1'b1; en = 1'b1; cin = 1'b1;
    @(negedge clk); d = 4'd13;
    @(negedge clk);
    #1;
    chk("clamp_q", q_a, 9);
    chk("clamp_wrap", wrap_a, 0);
    d = 4'd3;
    @(negedge clk);
    #1 chk("load3_q", q_a, 3);

    // Direction flip and carry-in gating.
    load = 1'b1; d = 4'd5;
    @(negedge clk); load = 1'b0; up = 1'b1;
    @(negedge clk); #1 chk("flip_q6", q_a, 6);
    up = 1'b0;
    @(negedge clk); #1 chk("flip_q5", q_a, 5);
    up = 1'b1;
    @(negedge clk); #1 chk("flip_q6b", q_a, 6);
    cin = 1'b0;
    @(negedge clk); #1;
    chk("gate_hold_q", q_a, 6);
    chk("gate_cout", cout_a, 0);
    @(negedge clk); #1 chk("gate_hold_q2", q_a, 6);

    // Two-stage decimal cascade.
    c_en = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      #1;
      chk("casc_val", int'(hi_q) * 10 + int'(lo_q), i % 100);
      chk("casc_hi_wrap", hi_wrap, (i == 100));
      chk("casc_lo_wrap", lo_wrap, (i > 0) && (i % 10 == 0));
      @(negedge clk);
    end
    c_en = 1'b0;

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 3) != 0);
      cin  = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 7) == 0);
      d    = W'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        #1 clr = 1'b1;
        #1 chk("rand_clr_q", q_a, 0);
        #1 clr = 1'b0;
      end
    end

    @(negedge clk);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
